// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED pattern sequencer: request modes, FSM states, LED count.
package led_seq_pkg;

  localparam int NUM_LEDS = 5;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_ALL_ON = 2'd1;
  localparam logic [1:0] MODE_CHASE  = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_ALL_ON = 3'd1,
    ST_CHASE  = 3'd2,
    ST_BLINK  = 3'd3,
    ST_LOAD   = 3'd4
  } state_t;

  function automatic state_t mode_to_state(input logic [1:0] m);
    state_t s;
    case (m)
      MODE_OFF:    s = ST_OFF;
      MODE_ALL_ON: s = ST_ALL_ON;
      MODE_CHASE:  s = ST_CHASE;
      MODE_BLINK:  s = ST_BLINK;
      default:     s = ST_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/led_seq_ctrl_tick_gen.sv
// Step prescaler: counts 0..DIV-1 and pulses tick on the last count; clr forces it back to 0.
module led_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/led_seq_ctrl.sv
// Five-LED pattern sequencer (off / all-on / chase / blink) with a valid/ready mode request.
// Optional brightness PWM gating is enabled by defining LED_SEQ_PWM_EN.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int CLK_HZ   = 12000000,
  parameter int STEP_HZ  = 8,
  parameter int PWM_BITS = 8,
  parameter int DUTY     = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       mode_valid,
  output logic       mode_ready,
  output logic       LED0,
  output logic       LED1,
  output logic       LED2,
  output logic       LED3,
  output logic       LED4
);

  localparam int DIV = CLK_HZ / STEP_HZ;

  state_t                state;
  state_t                state_nx;
  logic [1:0]            mode_q;
  logic                  ready_q;
  logic [2:0]            pos;
  logic                  phase;
  logic [NUM_LEDS-1:0]   pat;
  logic [NUM_LEDS-1:0]   led_out;
  logic                  accept;
  logic                  tick;
  logic                  clr;
  logic                  running;

  assign accept  = mode_valid & ready_q;
  assign running = (state == ST_CHASE) || (state == ST_BLINK);
  // An accepted request wins over a coincident tick, so the prescaler restarts too.
  assign clr     = accept | ~running;

  led_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    state_nx = state;
    if (accept) begin
      state_nx = ST_LOAD;
    end else if (state == ST_LOAD) begin
      state_nx = mode_to_state(mode_q);
    end else begin
      state_nx = state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_OFF;
      ready_q <= 1'b1;
      mode_q  <= MODE_OFF;
    end else begin
      state   <= state_nx;
      ready_q <= (state_nx != ST_LOAD);
      if (accept) begin
        mode_q <= mode;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos   <= 3'd0;
      phase <= 1'b0;
    end else if (state == ST_LOAD) begin
      pos   <= 3'd0;
      phase <= 1'b0;
    end else if (tick && !accept) begin
      if (state == ST_CHASE) begin
        pos <= (pos == 3'd4) ? 3'd0 : pos + 3'd1;
      end
      if (state == ST_BLINK) begin
        phase <= ~phase;
      end
    end
  end

  // Pattern register: reflects the state/pos of the previous cycle; LOAD holds the old pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat <= '0;
    end else begin
      case (state)
        ST_OFF:    pat <= 5'b00000;
        ST_ALL_ON: pat <= 5'b11111;
        ST_CHASE:  pat <= 5'b00001 << pos;
        ST_BLINK:  pat <= {NUM_LEDS{phase}};
        ST_LOAD:   pat <= pat;
        default:   pat <= 5'b00000;
      endcase
    end
  end

`ifdef LED_SEQ_PWM_EN
  localparam logic [PWM_BITS:0] DUTY_V = (PWM_BITS + 1)'(DUTY);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_on;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  assign pwm_on  = ({1'b0, pwm_cnt} < DUTY_V);
  assign led_out = pat & {NUM_LEDS{pwm_on}};
`else
  logic pwm_cfg_unused;
  assign pwm_cfg_unused = (PWM_BITS > 0) ^ (DUTY > 0);
  assign led_out        = pat;
`endif

  assign mode_ready = ready_q;
  assign LED0 = led_out[0];
  assign LED1 = led_out[1];
  assign LED2 = led_out[2];
  assign LED3 = led_out[3];
  assign LED4 = led_out[4];

endmodule
